// File: rtl/i2c_scl_timer.sv
// I2C SCL bit-timing generator: open-drain SCL drive, SDA phase strobes,
// clock-stretch tracking with timeout, and START/STOP hold windows.
module i2c_scl_timer #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SCL_HZ      = 100_000,
    parameter int unsigned STRETCH_MAX = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic scl_in,
    output logic scl_oe,
    output logic scl_fall,
    output logic change_tick,
    output logic scl_rise,
    output logic sample_tick,
    output logic stretching,
    output logic timeout,
    output logic busy
);

    localparam int unsigned QTR = CLK_HZ / (4 * SCL_HZ);

    // Phase counter spans up to the 2*QTR-cycle hold window.
    localparam int unsigned CW = (QTR >= 2) ? $clog2(2 * QTR) : 2;

    // Stretch counter only needs to reach STRETCH_MAX-1.
    localparam int unsigned SW = (STRETCH_MAX > 2) ? $clog2(STRETCH_MAX) : 1;

    localparam logic [CW-1:0] QTR_LAST  = CW'(QTR - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(2 * QTR - 1);
    localparam logic [SW-1:0] STR_LAST  = SW'(STRETCH_MAX - 1);

    if (QTR < 2) begin : g_qtr_chk
        $error("i2c_scl_timer: QTR must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_LOW_A,
        S_LOW_B,
        S_WAIT_HIGH,
        S_HIGH_A,
        S_HIGH_B
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] str_q, str_d;

    logic          sync1_q;
    logic          scl_s_q;

    logic          oe_q, oe_d;
    logic          fall_q, fall_d;
    logic          chg_q, chg_d;
    logic          rise_q, rise_d;
    logic          smp_q, smp_d;
    logic          to_q, to_d;

    logic          qtr_end;
    logic          hold_end;

    assign qtr_end  = (cnt_q == QTR_LAST);
    assign hold_end = (cnt_q == HOLD_LAST);

    // Two-flop synchronizer for the SCL pad readback; idles high like the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            scl_s_q <= 1'b1;
        end else begin
            sync1_q <= scl_in;
            scl_s_q <= sync1_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            str_q   <= '0;
            oe_q    <= 1'b0;
            fall_q  <= 1'b0;
            chg_q   <= 1'b0;
            rise_q  <= 1'b0;
            smp_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            str_q   <= str_d;
            oe_q    <= oe_d;
            fall_q  <= fall_d;
            chg_q   <= chg_d;
            rise_q  <= rise_d;
            smp_q   <= smp_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic; strobes are decided on the transition edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        str_d   = '0;
        oe_d    = oe_q;
        fall_d  = 1'b0;
        chg_d   = 1'b0;
        rise_d  = 1'b0;
        smp_d   = 1'b0;
        to_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                oe_d  = 1'b0;
                cnt_d = '0;
                if (en) begin
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                oe_d = 1'b0;
                if (hold_end) begin
                    if (en) begin
                        state_d = S_LOW_A;
                        oe_d    = 1'b1;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_LOW_A: begin
                oe_d = 1'b1;
                if (qtr_end) begin
                    state_d = S_LOW_B;
                    chg_d   = 1'b1;
                end
            end

            S_LOW_B: begin
                oe_d = 1'b1;
                if (qtr_end) begin
                    state_d = S_WAIT_HIGH;
                    oe_d    = 1'b0;
                end
            end

            S_WAIT_HIGH: begin
                oe_d  = 1'b0;
                cnt_d = '0;
                str_d = str_q + SW'(1);
                if (scl_s_q) begin
                    state_d = S_HIGH_A;
                    rise_d  = 1'b1;
                end else if (str_q == STR_LAST) begin
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end
            end

            S_HIGH_A: begin
                oe_d = 1'b0;
                if (qtr_end) begin
                    state_d = S_HIGH_B;
                    smp_d   = 1'b1;
                end
            end

            S_HIGH_B: begin
                oe_d = 1'b0;
                if (qtr_end) begin
                    if (en) begin
                        state_d = S_LOW_A;
                        oe_d    = 1'b1;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                oe_d    = 1'b0;
            end
        endcase

        // Every phase starts its count from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
            str_d = '0;
        end
    end

    assign scl_oe      = oe_q;
    assign scl_fall    = fall_q;
    assign change_tick = chg_q;
    assign scl_rise    = rise_q;
    assign sample_tick = smp_q;
    assign timeout     = to_q;
    assign busy        = (state_q != S_IDLE);

    // Slave has held SCL low past the first WAIT_HIGH cycle.
    assign stretching = (state_q == S_WAIT_HIGH) && !scl_s_q
                        && (str_q != '0);

endmodule
